aes_unmask: RTL and testbench
=============================

Name: aes_unmask

Overview:
- Inverse of the aes_mask datapath.
- Takes a masked 128-bit word produced by the masking core after init, N next operations and finalize, plus the same key, keylen and finalize block.
- Iteratively recovers the original init block, so firmware and testbenches can check or remove the mask.
- Sits beside the masking core on the same key/block buses, with a start/ready/valid handshake.

Parameters:
- MAX_ROUNDS, 15: largest round count accepted; sets the counter width to 4 bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when ready=1
- rounds  in  4  N, the number of next operations the masking core performed (0..MAX_ROUNDS)
- key  in  128  key used by the masking core at init/next
- keylen  in  1  0: key rotation 19 bits, 1: key rotation 22 bits
- fin_block  in  128  block value the masking core saw at finalize
- masked  in  128  masked word to undo
- ready  out  1  idle, can accept start
- result_valid  out  1  one-cycle pulse when result is final
- result  out  128  recovered block; held until the next start

Behaviour:
- Reset (reset_n=0 at posedge): FSM=IDLE, state_reg=0, rk_reg=0, cnt=0, ready=1, result_valid=0, result=0.
- Reset mid-operation aborts immediately; no valid pulse follows.
- Forward model being inverted:
  - S0 = block, rk0 = key.
  - S_i = MixColumns(S_{i-1}) ^ rk_{i-1}.
  - rk_i = rotr(rk_{i-1}, R), with R=19 (keylen=0) or R=22 (keylen=1).
  - masked = S_N ^ fin_block.
- Inverse recurrence: S_{i-1} = InvMixColumns(S_i ^ rk_{i-1}).
- FSM states: IDLE, KEYSETUP, UNMASK.
- IDLE, start=1 (edge E0):
  - state_reg = masked ^ fin_block; rk_reg = key; keylen and rounds latched; ready drops.
  - If N=0: result_valid=1 on E0, stay in IDLE, ready stays 1.
  - If N=1: go to UNMASK with cnt=1.
  - If N>=2: go to KEYSETUP with cnt=N-1.
- KEYSETUP, one edge per cycle:
  - rk_reg = rotr(rk_reg, R); cnt decrements.
  - When cnt reaches 1 on this edge: go to UNMASK, cnt=N.
  - Result: after N-1 edges, rk_reg = rotr^(N-1)(key).
- UNMASK, one edge per cycle:
  - state_reg = InvMixColumns(state_reg ^ rk_reg); rk_reg = rotl(rk_reg, R); cnt decrements.
  - On the edge where cnt goes 1->0: result_valid=1 for one cycle, go to IDLE, ready=1.
- Latency: valid is set on edge E0+max(2N-1,0). Examples: N=1 sets it on E1, N=15 on E29.
- start while ready=0 is ignored; it is neither queued nor able to corrupt inputs.
- Inputs are sampled only at E0, so later input changes have no effect.
- start on the same edge that valid is set is not accepted (ready is 0 during that cycle).
- rounds > MAX_ROUNDS: clamp to MAX_ROUNDS (matters only if MAX_ROUNDS < 15).
- result = state_reg, combinationally.
- InvMixColumns: per 32-bit column, bytes b0..b3 big-endian, rows {14,11,13,9} rotated per row, GF(2^8) modulus 0x11b.

Decomposition:
- Package aes_mask_pkg holds:
  - constants ROT_128=19, ROT_256=22
  - functions gm2, gm3, mixw, mixcolumns
  - functions gm9, gm11, gm13, gm14, inv_mixw
  - FSM state encodings
- The package is shared with aes_mask, so the forward and inverse math come from one source.
- One sub-module: aes_inv_mixcolumns, purely combinational 128-bit in/out, reused by the bench model.

Test Plan:
- InvMixColumns vector: rounds=1, key=0, fin_block=0, masked={32'h8e4da1bc}x4 -> result_valid after E1; result={32'hdb135345}x4.
- Zero rounds: rounds=0, masked=128'h00112233445566778899aabbccddeeff, fin_block=128'hffffffff000000000000000000000000 -> valid on E0; result=128'hffeeddcc445566778899aabbccddeeff; ready stays 1.
- Round trip:
  - Drive aes_mask with init(block=128'h3243f6a8885a308d313198a2e0370734, key=128'h2b7e151628aed2a6abf7158809cf4f3c), 10 next, finalize.
  - Feed its result to this block with rounds=10, keylen=0, then repeat with keylen=1.
  - Required: result == block in both cases; valid on E19.
- Busy protection: pulse start again at E0+3 with different masked and rounds -> first job's result is unchanged; exactly one valid pulse; ready=1 afterwards.
- Reset mid-operation: rounds=8, assert reset_n=0 at E0+5 -> next cycle ready=1, result=0, result_valid=0; no valid pulse for 20 cycles.
- Back-to-back: start re-asserted the cycle ready returns, rounds=15 then rounds=2 -> valids on E0+29 and the second job's E0'+3; both results match the forward-model reference.

Source files
------------

// File: rtl/aes_mask_pkg.sv
// Shared GF(2^8) column math, key rotations and FSM encodings
// for the aes_mask / aes_unmask pair.
package aes_mask_pkg;

    localparam int ROT_128 = 19;
    localparam int ROT_256 = 22;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_KEYSETUP = 2'd1,
        ST_UNMASK   = 2'd2
    } unmask_state_e;

    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] x);
        return gm2(x) ^ x;
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ x;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] x);
        return gm2(gm2(gm2(x)) ^ x) ^ x;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] x);
        return gm2(gm2(gm2(x) ^ x)) ^ x;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] x);
        return gm2(gm2(gm2(x) ^ x) ^ x);
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixw(s[127:96]), mixw(s[95:64]),
                mixw(s[63:32]), mixw(s[31:0])};
    endfunction

    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
                gm9(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
                gm13(b0) ^ gm9(b1) ^ gm14(b2) ^ gm11(b3),
                gm11(b0) ^ gm13(b1) ^ gm9(b2) ^ gm14(b3)};
    endfunction

    // kl=0 rotates by ROT_128, kl=1 by ROT_256
    function automatic logic [127:0] rotr_key(input logic [127:0] x,
                                              input logic kl);
        return kl ? {x[ROT_256-1:0], x[127:ROT_256]}
                  : {x[ROT_128-1:0], x[127:ROT_128]};
    endfunction

    function automatic logic [127:0] rotl_key(input logic [127:0] x,
                                              input logic kl);
        return kl ? {x[127-ROT_256:0], x[127:128-ROT_256]}
                  : {x[127-ROT_128:0], x[127:128-ROT_128]};
    endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
// Combinational 128-bit InvMixColumns, four independent columns.
module aes_inv_mixcolumns
    import aes_mask_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign dout[32*c +: 32] = inv_mixw(din[32*c +: 32]);
    end

endmodule

// File: rtl/aes_unmask.sv
// Iterative inverse of the aes_mask datapath: rewinds the key schedule,
// then peels N rounds of MixColumns/key-add off the masked word.
module aes_unmask
    import aes_mask_pkg::*;
#(
    parameter int MAX_ROUNDS = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [3:0]   rounds,
    input  logic [127:0] key,
    input  logic         keylen,
    input  logic [127:0] fin_block,
    input  logic [127:0] masked,
    output logic         ready,
    output logic         result_valid,
    output logic [127:0] result
);

    unmask_state_e fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  rk_q, rk_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    n_q, n_d;
    logic          kl_q, kl_d;
    logic          valid_q, valid_d;
    logic [127:0]  inv_out;
    logic [3:0]    n_clamp;
    logic          over;

    assign over    = 6'(MAX_ROUNDS) < {2'b00, rounds};
    assign n_clamp = over ? 4'(MAX_ROUNDS) : rounds;

    aes_inv_mixcolumns u_inv (
        .din  (state_q ^ rk_q),
        .dout (inv_out)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rk_q    <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            kl_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            kl_q    <= kl_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        kl_d    = kl_q;
        valid_d = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = masked ^ fin_block;
                    rk_d    = key;
                    kl_d    = keylen;
                    n_d     = n_clamp;
                    if (n_clamp == 4'd0) begin
                        valid_d = 1'b1;
                    end else if (n_clamp == 4'd1) begin
                        fsm_d = ST_UNMASK;
                        cnt_d = 4'd1;
                    end else begin
                        fsm_d = ST_KEYSETUP;
                        cnt_d = n_clamp - 4'd1;
                    end
                end
            end
            // walk the key forward to rk_{N-1}
            ST_KEYSETUP: begin
                rk_d = rotr_key(rk_q, kl_q);
                if (cnt_q == 4'd1) begin
                    fsm_d = ST_UNMASK;
                    cnt_d = n_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_UNMASK: begin
                state_d = inv_out;
                rk_d    = rotl_key(rk_q, kl_q);
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    valid_d = 1'b1;
                    fsm_d   = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    assign ready        = (fsm_q == ST_IDLE);
    assign result_valid = valid_q;
    assign result       = state_q;

endmodule

// File: tb/tb_aes_unmask.sv
// Self-checking bench: forward masking model in the bench, unmask must
// recover the original block with the documented latency.
module tb_aes_unmask;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [3:0]   rounds;
    logic [127:0] key;
    logic         keylen;
    logic [127:0] fin_block;
    logic [127:0] masked;
    logic         ready;
    logic         result_valid;
    logic [127:0] result;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_unmask #(.MAX_ROUNDS(15)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .rounds       (rounds),
        .key          (key),
        .keylen       (keylen),
        .fin_block    (fin_block),
        .masked       (masked),
        .ready        (ready),
        .result_valid (result_valid),
        .result       (result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mc(input logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0] b [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) b[r] = s[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = gmul(8'd2, b[r]) ^ gmul(8'd3, b[(r+1)%4])
                                     ^ b[(r+2)%4] ^ b[(r+3)%4];
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_rotr(input logic [127:0] x,
                                              input logic kl);
        int r = kl ? 22 : 19;
        return (x >> r) | (x << (128 - r));
    endfunction

    // what the masking core produces after init, n next, finalize
    function automatic logic [127:0] ref_mask(input logic [127:0] blk,
                                              input logic [127:0] k,
                                              input logic kl,
                                              input int n,
                                              input logic [127:0] fin);
        logic [127:0] s = blk;
        logic [127:0] rk = k;
        for (int i = 0; i < n; i++) begin
            s  = ref_mc(s) ^ rk;
            rk = ref_rotr(rk, kl);
        end
        return s ^ fin;
    endfunction

    function automatic int exp_lat(input int n);
        return (n == 0) ? 0 : 2 * n - 1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_job(input logic [127:0] m, input logic [127:0] f,
                           input logic [127:0] k, input logic kl,
                           input logic [3:0] n, input logic [127:0] exp,
                           input string tag);
        int lat;
        masked = m; fin_block = f; key = k; keylen = kl;
        rounds = n; start = 1'b1;
        chk({tag, "_rdy0"}, 128'(ready), 128'(1));
        tick();
        start = 1'b0;
        lat = 0;
        while (!result_valid && lat < 64) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat(int'(n))));
        chk({tag, "_res"}, result, exp);
        chk({tag, "_rdy1"}, 128'(ready), 128'(1));
        tick();
        chk({tag, "_pulse"}, 128'(result_valid), 128'(0));
    endtask

    logic [127:0] blk, k0, f0, m0, res1;
    int lat1, lat2, pulses;

    initial begin
        reset_n = 1'b0; start = 1'b0; rounds = '0; key = '0;
        keylen = 1'b0; fin_block = '0; masked = '0;
        tick(); tick();
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_valid", 128'(result_valid), 128'(0));
        chk("rst_result", result, 128'(0));
        reset_n = 1'b1;
        tick();

        run_job({4{32'h8e4da1bc}}, '0, '0, 1'b0, 4'd1,
                {4{32'hdb135345}}, "invmc");

        run_job(128'h00112233445566778899aabbccddeeff,
                128'hffffffff000000000000000000000000, rnd128(), 1'b0, 4'd0,
                128'hffeeddcc445566778899aabbccddeeff, "zero");

        blk = 128'h3243f6a8885a308d313198a2e0370734;
        k0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        f0  = 128'h000102030405060708090a0b0c0d0e0f;
        run_job(ref_mask(blk, k0, 1'b0, 10, f0), f0, k0, 1'b0, 4'd10,
                blk, "rt_kl0");
        run_job(ref_mask(blk, k0, 1'b1, 10, f0), f0, k0, 1'b1, 4'd10,
                blk, "rt_kl1");

        // second start while busy must be ignored
        blk = rnd128(); k0 = rnd128(); f0 = rnd128();
        masked = ref_mask(blk, k0, 1'b1, 5, f0); fin_block = f0;
        key = k0; keylen = 1'b1; rounds = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0; lat1 = -1; res1 = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (result_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat1 = c;
                    res1 = result;
                end
            end
            if (c == 2) begin
                masked = rnd128(); fin_block = rnd128(); key = rnd128();
                keylen = 1'b0; rounds = 4'd2; start = 1'b1;
            end
            if (c == 3) start = 1'b0;
        end
        chk("busy_pulses", 128'(pulses), 128'(1));
        chk("busy_lat", 128'(lat1), 128'(9));
        chk("busy_res", res1, blk);
        chk("busy_ready", 128'(ready), 128'(1));

        // reset in the middle of a job
        blk = rnd128(); k0 = rnd128(); f0 = rnd128();
        masked = ref_mask(blk, k0, 1'b0, 8, f0); fin_block = f0;
        key = k0; keylen = 1'b0; rounds = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        chk("mid_rst_ready", 128'(ready), 128'(1));
        chk("mid_rst_result", result, 128'(0));
        chk("mid_rst_valid", 128'(result_valid), 128'(0));
        reset_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            tick();
            if (result_valid) pulses++;
        end
        chk("mid_rst_nopulse", 128'(pulses), 128'(0));

        // back-to-back: restart in the same cycle ready returns
        blk = rnd128(); k0 = rnd128(); f0 = rnd128();
        masked = ref_mask(blk, k0, 1'b0, 15, f0); fin_block = f0;
        key = k0; keylen = 1'b0; rounds = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        lat1 = 0;
        while (!result_valid && lat1 < 64) begin
            tick();
            lat1++;
        end
        chk("b2b_lat1", 128'(lat1), 128'(29));
        chk("b2b_res1", result, blk);
        chk("b2b_rdy", 128'(ready), 128'(1));
        blk = rnd128(); k0 = rnd128(); f0 = rnd128();
        masked = ref_mask(blk, k0, 1'b1, 2, f0); fin_block = f0;
        key = k0; keylen = 1'b1; rounds = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        lat2 = 0;
        while (!result_valid && lat2 < 64) begin
            tick();
            lat2++;
        end
        chk("b2b_lat2", 128'(lat2), 128'(3));
        chk("b2b_res2", result, blk);
        tick();

        for (int j = 0; j < 10; j++) begin
            logic [3:0] n;
            logic kl;
            n  = 4'($urandom_range(0, 15));
            kl = 1'($urandom_range(0, 1));
            blk = rnd128(); k0 = rnd128(); f0 = rnd128();
            run_job(ref_mask(blk, k0, kl, int'(n), f0), f0, k0, kl, n,
                    blk, $sformatf("rand%0d", j));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
